// File: rtl/jesd204_tx_link.sv
// jesd204_tx_link: JESD204B transmit link layer producing CGS, ILAS and data octets
// with per-octet K flags for the 8B/10B encoder, aligned to the SYSREF-derived LMFC.
module jesd204_tx_link #(
   parameter int NUM_LANES             = 4,
   parameter int OCTETS_PER_FRAME      = 2,
   parameter int FRAMES_PER_MULTIFRAME = 16
) (
   input  logic                      jesd_clk,
   input  logic                      reset,
   input  logic                      jesd_sysref,
   input  logic                      jesd_sync,
   input  logic [111:0]              ilas_cfg,
   input  logic [32*NUM_LANES-1:0]   tx_data,
   input  logic                      tx_valid,
   output logic                      tx_ready,
   output logic [32*NUM_LANES-1:0]   phy_data,
   output logic [4*NUM_LANES-1:0]    phy_charisk,
   output logic [1:0]                link_state,
   output logic                      lmfc_edge,
   output logic                      underflow
);
   localparam int FK = OCTETS_PER_FRAME * FRAMES_PER_MULTIFRAME;
   localparam int BPM = FK / 4;
   localparam int LW = $clog2(BPM);
   localparam logic [LW-1:0] LMAX = LW'(BPM - 1);
   localparam logic [9:0] JLAST = 10'(FK - 1);

   typedef enum logic [1:0] {CGS = 2'd0, ILAS = 2'd1, DATA = 2'd2} state_t;

   state_t state, state_n;
   logic sync_m, sync_s, sync_q, sysref_q;
   logic [LW-1:0] lmfc_cnt, beat;
   logic [1:0] mf;
   logic [127:0] cfg_q;
   logic resync, ilas_last;
   logic [31:0] ilas_word;
   logic [3:0] ilas_k;

   // a lone low SYNC~ cycle is an error report; two in a row request resync
   assign resync = !sync_s && !sync_q;
   assign ilas_last = mf == 2'd3 && beat == LMAX;
   assign tx_ready = state == DATA;

   always_comb begin
      state_n = state;
      state_n = state == CGS ? ((sync_s && lmfc_cnt == LMAX) ? ILAS : CGS) :
                resync ? CGS :
                (state == ILAS && ilas_last) ? DATA : state;
   end

   // j is the octet index within the current ILAS multiframe
   for (genvar n = 0; n < 4; n++) begin : g_oct
      logic [9:0] j;
      logic [3:0] idx;
      assign j = 10'({beat, 2'b00}) + 10'(n);
      assign idx = 4'(j - 10'd2);
      assign ilas_k[n] = j == 10'd0 || j == JLAST || (mf == 2'd1 && j == 10'd1);
      assign ilas_word[8*n +: 8] = j == 10'd0 ? 8'h1C :
                                   j == JLAST ? 8'h7C :
                                   (mf == 2'd1 && j == 10'd1) ? 8'h9C :
                                   (mf == 2'd1 && j >= 10'd2 && j <= 10'd15) ? cfg_q[{idx, 3'b000} +: 8] :
                                   j[7:0];
   end

   always_ff @(posedge jesd_clk or posedge reset) begin
      if (reset) begin
         state       <= CGS;
         sync_m      <= 1'b0;
         sync_s      <= 1'b0;
         sync_q      <= 1'b0;
         sysref_q    <= 1'b0;
         lmfc_cnt    <= '0;
         beat        <= '0;
         mf          <= 2'd0;
         cfg_q       <= '0;
         phy_data    <= {4*NUM_LANES{8'hBC}};
         phy_charisk <= '1;
         link_state  <= 2'd0;
         lmfc_edge   <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         sync_m     <= jesd_sync;
         sync_s     <= sync_m;
         sync_q     <= sync_s;
         sysref_q   <= jesd_sysref;
         lmfc_cnt   <= ((jesd_sysref && !sysref_q) || lmfc_cnt == LMAX) ? '0 : lmfc_cnt + 1'b1;
         state      <= state_n;
         if (state == CGS) begin
            beat <= '0;
            mf   <= 2'd0;
            if (state_n == ILAS)
               cfg_q <= {16'h0, ilas_cfg};
         end else if (state == ILAS) begin
            beat <= beat == LMAX ? '0 : beat + 1'b1;
            mf   <= beat == LMAX ? mf + 1'b1 : mf;
         end
         lmfc_edge   <= lmfc_cnt == '0;
         link_state  <= state;
         underflow   <= state == DATA && !tx_valid;
         phy_data    <= state == CGS ? {4*NUM_LANES{8'hBC}} :
                        state == ILAS ? {NUM_LANES{ilas_word}} :
                        tx_valid ? tx_data : '0;
         phy_charisk <= state == CGS ? '1 :
                        state == ILAS ? {NUM_LANES{ilas_k}} : '0;
      end
   end
endmodule

// File: tb/tb_jesd204_tx_link.sv
// tb_jesd204_tx_link: scoreboard bench for jesd204_tx_link with F=2, K=16, four lanes.
module tb_jesd204_tx_link;
   localparam int NL = 4;
   localparam int FK = 32;
   localparam int BPM = 8;
   typedef logic [148:0] obs_t;
   localparam obs_t RESET_OBS = {{16{8'hBC}}, 16'hFFFF, 2'd0, 1'b0, 1'b0, 1'b0};

   logic jesd_clk = 1'b0;
   logic reset = 1'b1;
   logic jesd_sysref = 1'b0;
   logic jesd_sync = 1'b0;
   logic tx_valid = 1'b0;
   logic [111:0] ilas_cfg = '0;
   logic [32*NL-1:0] tx_data = '0;
   logic tx_ready, lmfc_edge, underflow;
   logic [32*NL-1:0] phy_data;
   logic [4*NL-1:0] phy_charisk;
   logic [1:0] link_state;

   jesd204_tx_link #(.NUM_LANES(NL), .OCTETS_PER_FRAME(2), .FRAMES_PER_MULTIFRAME(16)) dut (
      .jesd_clk(jesd_clk), .reset(reset), .jesd_sysref(jesd_sysref), .jesd_sync(jesd_sync),
      .ilas_cfg(ilas_cfg), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .phy_data(phy_data), .phy_charisk(phy_charisk), .link_state(link_state),
      .lmfc_edge(lmfc_edge), .underflow(underflow)
   );

   always #5 jesd_clk = ~jesd_clk;

   int n_checks = 0;
   int n_errors = 0;
   obs_t sb[$];
   int m_state, m_lmfc, m_ilas;
   logic m_sysq, m_s1, m_ss, m_sq;
   logic [111:0] m_cfg;
   logic [31:0] b8_word;
   int cyc = 0;
   int b0_cyc = -1;
   logic b0_seen = 1'b0;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic obs_t obs();
      return {phy_data, phy_charisk, link_state, underflow, lmfc_edge, tx_ready};
   endfunction

   function automatic logic [8:0] ilas_oct(input int cnt, input int n, input logic [111:0] cfg);
      int m;
      int j;
      m = cnt / BPM;
      j = 4 * (cnt % BPM) + n;
      if (j == 0) return {1'b1, 8'h1C};
      if (j == FK - 1) return {1'b1, 8'h7C};
      if (m == 1 && j == 1) return {1'b1, 8'h9C};
      if (m == 1 && j >= 2 && j <= 15) return {1'b0, cfg[8*(j-2) +: 8]};
      return {1'b0, 8'(j)};
   endfunction

   task automatic model_reset();
      m_state = 0; m_lmfc = 0; m_ilas = 0;
      m_sysq = 1'b0; m_s1 = 1'b0; m_ss = 1'b0; m_sq = 1'b0;
      m_cfg = '0;
   endtask

   task automatic rnd_data();
      tx_data = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // one clock: predict the registered outputs, push, clock, pop and compare
   task automatic step();
      logic [127:0] pd;
      logic [15:0] pk;
      logic [8:0] o;
      int ns, ni, bt;
      if (m_state == 0) begin
         pd = {16{8'hBC}};
         pk = '1;
      end else if (m_state == 1) begin
         pd = '0;
         pk = '0;
         for (int n = 0; n < 4; n++) begin
            o = ilas_oct(m_ilas, n, m_cfg);
            for (int l = 0; l < NL; l++) begin
               pd[32*l+8*n +: 8] = o[7:0];
               pk[4*l+n] = o[8];
            end
         end
      end else begin
         pd = tx_valid ? tx_data : '0;
         pk = '0;
      end
      bt = m_state == 1 ? m_ilas : -1;
      ns = m_state;
      ni = m_ilas;
      if (m_state == 0) begin
         if (m_ss && m_lmfc == BPM - 1) begin
            ns = 1;
            ni = 0;
            m_cfg = ilas_cfg;
         end
      end else if (!m_ss && !m_sq) ns = 0;
      else if (m_state == 1) begin
         if (m_ilas == 4 * BPM - 1) ns = 2;
         else ni = m_ilas + 1;
      end
      sb.push_back({pd, pk, 2'(m_state), m_state == 2 && !tx_valid, m_lmfc == 0, ns == 2});
      m_lmfc = (jesd_sysref && !m_sysq) ? 0 : (m_lmfc + 1) % BPM;
      m_sysq = jesd_sysref;
      m_sq = m_ss;
      m_ss = m_s1;
      m_s1 = jesd_sync;
      m_state = ns;
      m_ilas = ni;
      @(posedge jesd_clk);
      #1;
      check("cycle", obs(), sb.pop_front());
      if (bt == 0) begin
         if (!b0_seen) b0_cyc = cyc;
         b0_seen = 1'b1;
         check("ilas_b0", {phy_charisk[3:0], phy_data[31:0]}, {4'b0001, 32'h0302011C});
         check("ilas_on_lmfc", lmfc_edge, 1);
      end
      if (bt == 7) check("ilas_b7", {phy_charisk[3:0], phy_data[31:0]}, {4'b1000, 32'h7C1E1D1C});
      if (bt == 8) check("ilas_b8", {phy_charisk[3:0], phy_data[31:0]}, {4'b0011, b8_word});
      cyc++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      model_reset();
      repeat (3) @(posedge jesd_clk);
      #2;
      check("reset_outputs", obs(), RESET_OBS);
      reset = 1'b0;
      // CGS with SYNC~ held low, SYSREF at cycles 10 and 30
      for (int c = 0; c < 50; c++) begin
         jesd_sysref = (c == 10 || c == 30);
         step();
         if (c >= 11 && c < 30) check("lmfc_first", lmfc_edge, (c - 11) % 8 == 0);
         if (c >= 31) check("lmfc_second", lmfc_edge, (c - 31) % 8 == 0);
      end
      jesd_sysref = 1'b0;
      check("cgs_outputs", obs(), {{16{8'hBC}}, 16'hFFFF, 2'd0, 1'b0, lmfc_edge, 1'b0});
      // ILAS with config octets A0..AD
      for (int i = 0; i < 14; i++) ilas_cfg[8*i +: 8] = 8'hA0 + 8'(i);
      b8_word = 32'hA1A09C1C;
      jesd_sync = 1'b1;
      tx_valid = 1'b1;
      for (int c = 0; c < 80 && m_state != 2; c++) begin
         rnd_data();
         step();
      end
      rnd_data();
      step();
      check("ilas_seen", b0_seen, 1);
      check("enter_data", {link_state, tx_ready}, {2'd2, 1'b1});
      // data path and underflow
      rnd_data();
      tx_data[31:0] = 32'h11223344;
      step();
      check("data_lane0", {phy_charisk, phy_data[31:0]}, {16'h0, 32'h11223344});
      tx_valid = 1'b0;
      step();
      check("underflow", {underflow, phy_data}, {1'b1, 128'h0});
      tx_valid = 1'b1;
      rnd_data();
      step();
      check("underflow_pulse", underflow, 0);
      // single-cycle SYNC~ low is ignored
      jesd_sync = 1'b0;
      step();
      jesd_sync = 1'b1;
      repeat (6) begin rnd_data(); step(); end
      check("sync_glitch", link_state, 2);
      // sustained SYNC~ low forces CGS
      jesd_sync = 1'b0;
      for (int c = 0; c < 12 && m_state != 0; c++) begin rnd_data(); step(); end
      step();
      check("resync", {link_state, phy_data[31:0], phy_charisk[3:0]}, {2'd0, 32'hBCBCBCBC, 4'hF});
      jesd_sync = 1'b1;
      b0_seen = 1'b0;
      for (int c = 0; c < 80 && m_state != 2; c++) begin rnd_data(); step(); end
      step();
      check("relink_ilas", b0_seen, 1);
      check("relink_data", link_state, 2);
      // reset in the middle of ILAS, then re-enter with new config
      jesd_sync = 1'b0;
      for (int c = 0; c < 12 && m_state != 0; c++) step();
      for (int i = 0; i < 14; i++) ilas_cfg[8*i +: 8] = 8'hB0 + 8'(i);
      b8_word = 32'hB1B09C1C;
      jesd_sync = 1'b1;
      for (int c = 0; c < 40 && !(m_state == 1 && m_ilas == 5); c++) step();
      check("pre_reset_ilas", link_state, 1);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset", obs(), RESET_OBS);
      @(posedge jesd_clk);
      #1;
      check("reset_hold", obs(), RESET_OBS);
      #2;
      reset = 1'b0;
      model_reset();
      cyc = 0;
      b0_seen = 1'b0;
      b0_cyc = -1;
      for (int c = 0; c < 60 && m_state != 2; c++) begin rnd_data(); step(); end
      step();
      check("post_reset_ilas_start", b0_cyc, 8);
      check("post_reset_data", {link_state, tx_ready}, {2'd2, 1'b1});
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
